video_arbiter: RTL

VIDEO_ARBITER -- requirements
Module: video_arbiter

---
 rtl/video_arbiter_if.sv | 31 +++
 rtl/video_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/video_arbiter_if.sv
// Bundle of the video fetcher, CPU and DRAM controller signals of the video arbiter.
// The master modport is the environment side (fetcher/CPU/DRAM), the slave modport is the arbiter.
interface video_arbiter_if;
    logic        cend;
    logic        video_go;
    logic [1:0]  video_bw;
    logic [20:0] video_addr;
    logic        video_next;
    logic        video_strobe;
    logic [15:0] video_data;
    logic        cpu_req;
    logic        cpu_grant;
    logic        dram_req;
    logic [20:0] dram_addr;
    logic        dram_vid;
    logic        dram_stb;
    logic [15:0] dram_rdata;
    logic        arb_err;

    modport master (
        output cend, video_go, video_bw, video_addr, cpu_req, dram_stb, dram_rdata,
        input  video_next, video_strobe, video_data, cpu_grant, dram_req, dram_addr,
               dram_vid, arb_err
    );

    modport slave (
        input  cend, video_go, video_bw, video_addr, cpu_req, dram_stb, dram_rdata,
        output video_next, video_strobe, video_data, cpu_grant, dram_req, dram_addr,
               dram_vid, arb_err
    );
endinterface

// File: rtl/video_arbiter.sv
// Video/CPU DRAM slot arbiter. An 8-slot wheel advanced by cend decides, per
// slot, whether the video fetcher or the CPU gets the DRAM. Issued requests
// are tracked in a 4-deep owner FIFO so returning read data can be routed.
// Optional feature: define VIDEO_ARB_SLOT_REUSE_EN to let the CPU take
// video-eligible slots that the video fetcher does not use.
module video_arbiter (
    input  logic            clk,
    input  logic            rst,
    video_arbiter_if.slave  bus
);

    logic [2:0] slot;
    logic [3:0] owner_mem;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic [2:0] occupancy;
    logic       eligible;
    logic       fifo_full;
    logic       fifo_empty;
    logic       vid_grant;
    logic       cpu_grant_c;
    logic       pop;
    logic       head_vid;

    // Video eligibility of the current slot as a function of requested bandwidth
    always_comb begin
        eligible = 1'b0;
        case (bus.video_bw)
            2'b00:   eligible = (slot == 3'd0);
            2'b01:   eligible = (slot[1:0] == 2'd0);
            2'b10:   eligible = (slot[0] == 1'b0);
            default: eligible = 1'b1;
        endcase
    end

    // The request being issued this cycle is not yet counted, so include it
    // when deciding whether another grant still fits in the FIFO.
    assign occupancy  = count + {2'b00, bus.dram_req};
    assign fifo_full  = (occupancy >= 3'd4);
    assign fifo_empty = (count == 3'd0);
    assign vid_grant  = bus.cend & bus.video_go & eligible & ~fifo_full;
`ifdef VIDEO_ARB_SLOT_REUSE_EN
    assign cpu_grant_c = bus.cend & bus.cpu_req & ~vid_grant & ~fifo_full;
`else
    assign cpu_grant_c = bus.cend & bus.cpu_req & ~eligible & ~fifo_full;
`endif
    assign pop      = bus.dram_stb & ~fifo_empty;
    assign head_vid = owner_mem[rd_ptr];

    // Slot wheel advancing on every slot boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot <= 3'd0;
        else if (bus.cend)
            slot <= slot + 3'd1;
    end

    // Registered grant outputs, issued the cycle after the slot boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.dram_req   <= 1'b0;
            bus.dram_vid   <= 1'b0;
            bus.video_next <= 1'b0;
            bus.cpu_grant  <= 1'b0;
            bus.dram_addr  <= 21'd0;
        end else begin
            bus.dram_req   <= vid_grant | cpu_grant_c;
            bus.dram_vid   <= vid_grant;
            bus.video_next <= vid_grant;
            bus.cpu_grant  <= cpu_grant_c;
            bus.dram_addr  <= vid_grant ? bus.video_addr : 21'd0;
        end
    end

    // Owner FIFO: push the owner of each issued request, pop on each valid return
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_mem <= 4'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
        end else begin
            if (bus.dram_req) begin
                owner_mem[wr_ptr] <= bus.dram_vid;
                wr_ptr            <= wr_ptr + 2'd1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 2'd1;
            case ({bus.dram_req, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Route returning data to the video side and flag unexpected returns
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.video_strobe <= 1'b0;
            bus.video_data   <= 16'd0;
            bus.arb_err      <= 1'b0;
        end else begin
            bus.video_strobe <= pop & head_vid;
            if (pop && head_vid)
                bus.video_data <= bus.dram_rdata;
            if (bus.dram_stb && fifo_empty)
                bus.arb_err <= 1'b1;
        end
    end

endmodule
